cct_sequence_monitor: RTL
=========================

Name: cct_sequence_monitor

Overview:
- Downstream consumer of the 8-bit student-circuit sequence counter output.
- Verifies on-line that the incoming byte stream follows the counter's fixed 8-state cycle: 05, 0A, 14, 28, 50, A0, 41, 82, then back to 05.
- Acquires lock, then tracks expected values, counts completed laps and counts sequence errors.
- Feeds status LEDs and the lab scoreboard.

Parameters:
- LOCK_MATCHES, 3: consecutive correct samples, including the initial 05, needed before `locked` asserts. Legal range 1..8.
- LAP_W, 8: width of `lap_count`. Wraps modulo 2^LAP_W.
- ERR_W, 4: width of `err_count`. Saturates at 2^ERR_W-1.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- clear  input  1  synchronous, active-high reset.
- seq_in  input  8  sampled counter value; one sample per clock, no valid qualifier.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse for each mismatch detected in LOCKED.
- lap_count  output  LAP_W  completed laps while locked.
- err_count  output  ERR_W  saturating mismatch count.
- expected  output  8  value predicted for the next sample; 00 when not tracking.

Behaviour:
- Reset and timing:
  - One clock, `clk`. Reset `clear` is synchronous, active-high.
  - `clear`=1 at a posedge forces: state HUNT, `locked`=0, `err_pulse`=0, `lap_count`=0, `err_count`=0, `expected`=00, match counter=0.
  - `clear` has priority over all other events, including mid-lock.
  - All outputs are registered. The effect of the sample taken at edge N is visible after edge N.
- Successor function succ(v):
  - v==82 → 05
  - v==A0 → 41
  - otherwise v<<1, truncated to 8 bits.
- State machine (HUNT, VERIFY, LOCKED). Match counter is 4 bits.
  - HUNT, seq_in==05:
    - If LOCK_MATCHES==1: go to LOCKED.
    - Otherwise: go to VERIFY, match counter=1.
    - Either way: `expected`=0A.
  - HUNT, any other value: stay in HUNT, `expected`=00.
  - VERIFY, seq_in==expected:
    - Increment match counter; `expected`=succ(seq_in).
    - When the count reaches LOCK_MATCHES: go to LOCKED.
  - VERIFY, mismatch:
    - No error counted, no pulse.
    - If seq_in==05: restart VERIFY, count=1, `expected`=0A.
    - Otherwise: go to HUNT, `expected`=00.
  - LOCKED, seq_in==expected:
    - Stay in LOCKED; `expected`=succ(seq_in).
    - If seq_in==82: increment `lap_count` (wraps).
  - LOCKED, mismatch:
    - `err_pulse`=1 for exactly one cycle.
    - Increment `err_count` unless already saturated.
    - `locked` drops.
    - If seq_in==05: go to VERIFY, count=1, `expected`=0A.
    - Otherwise: go to HUNT, `expected`=00.
- Output rules:
  - `locked` = (state==LOCKED), registered.
  - `err_pulse` is never high two consecutive cycles. A mismatch leaves LOCKED, and errors are counted only in LOCKED.
- Lap counting:
  - Laps are counted only in LOCKED.
  - The 82 seen while still in VERIFY does not count.
  - Lap counting begins with the first 82 sampled while in LOCKED.
- Out-of-sequence values:
  - Values outside the 8-value set (e.g. 00, FF, 33) never match in any state.
- Sizing: match counter width 4 bits, sufficient for LOCK_MATCHES ≤ 8.

Test Plan:
1. Acquire lock. Stimulus: `clear` 1 cycle, then seq_in 05, 0A, 14. Required response: `locked`=1 after the edge sampling 14; `expected`=28; `err_count`=0.
2. Lap counting. Stimulus: after lock, stream two full laps (28…82, 05…82). Required response: `lap_count`=2; `err_pulse` never high.
3. Error while locked. Stimulus: while locked with `expected`=28, drive 33, then 50. Required response: `err_pulse` high for one cycle; `err_count`=1; `locked`=0; state HUNT; 50 ignored; `expected`=00.
4. Resync on 05. Stimulus: while locked with `expected`=50, drive 05, 0A, 14. Required response: `err_count` increments by 1; VERIFY entered with count=1; `locked` re-asserts after 14.
5. Saturation. Stimulus: with ERR_W=4, 20 lock/error episodes. Required response: `err_count` holds at 15; `err_pulse` still pulses on each episode.
6. Clear mid-operation. Stimulus: `clear` asserted while locked, with `lap_count`=3 and seq_in still valid. Required response: after that edge all outputs are 0 and the state is HUNT. With `clear` low and 05 next, VERIFY starts normally.

Source files
------------

// File: rtl/cct_sequence_monitor_if.sv
// rtl/cct_sequence_monitor_if.sv - sample stream and status bundle for the sequence monitor
interface cct_sequence_monitor_if #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
);
  logic [7:0]       seq_in;
  logic             locked;
  logic             err_pulse;
  logic [LAP_W-1:0] lap_count;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       expected;

  modport master (
    output seq_in,
    input  locked, err_pulse, lap_count, err_count, expected
  );

  modport slave (
    input  seq_in,
    output locked, err_pulse, lap_count, err_count, expected
  );
endinterface

// File: rtl/cct_sequence_monitor.sv
// rtl/cct_sequence_monitor.sv - on-line checker for the 8-state counter cycle 05,0A,14,28,50,A0,41,82
module cct_sequence_monitor #(
  parameter int LOCK_MATCHES = 3,
  parameter int LAP_W        = 8,
  parameter int ERR_W        = 4
) (
  input  logic                   clk,
  input  logic                   clear,
  cct_sequence_monitor_if.slave  mon
);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [7:0] V_FIRST  = 8'h05;
  localparam logic [7:0] V_SECOND = 8'h0A;
  localparam logic [7:0] V_LAST   = 8'h82;
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_MATCHES);

  logic [1:0]       state;
  logic [3:0]       match_cnt;
  logic [7:0]       expected_q;
  logic             err_pulse_q;
  logic [LAP_W-1:0] lap_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       next_cnt;
  logic             hit;

  function automatic logic [7:0] succ(input logic [7:0] v);
    case (v)
      8'h82:   succ = 8'h05;
      8'hA0:   succ = 8'h41;
      default: succ = {v[6:0], 1'b0};
    endcase
  endfunction

  // expected_q only ever holds in-cycle values while tracking, so stray values can never hit
  assign hit      = (mon.seq_in == expected_q);
  assign next_cnt = match_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= S_HUNT;
      match_cnt   <= 4'd0;
      expected_q  <= 8'h00;
      err_pulse_q <= 1'b0;
      lap_q       <= '0;
      err_q       <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state)
        S_HUNT: begin
          if (mon.seq_in == V_FIRST) begin
            state      <= (LOCK_CNT == 4'd1) ? S_LOCKED : S_VERIFY;
            match_cnt  <= 4'd1;
            expected_q <= V_SECOND;
          end else begin
            expected_q <= 8'h00;
          end
        end
        S_VERIFY: begin
          if (hit) begin
            match_cnt  <= next_cnt;
            expected_q <= succ(mon.seq_in);
            if (next_cnt >= LOCK_CNT) state <= S_LOCKED;
          end else if (mon.seq_in == V_FIRST) begin
            match_cnt  <= 4'd1;
            expected_q <= V_SECOND;
          end else begin
            state      <= S_HUNT;
            match_cnt  <= 4'd0;
            expected_q <= 8'h00;
          end
        end
        S_LOCKED: begin
          if (hit) begin
            expected_q <= succ(mon.seq_in);
            if (mon.seq_in == V_LAST) lap_q <= lap_q + LAP_W'(1);
          end else begin
            err_pulse_q <= 1'b1;
            if (err_q != '1) err_q <= err_q + ERR_W'(1);
            // A 05 on the error sample is treated as the start of a fresh acquisition
            if (mon.seq_in == V_FIRST) begin
              state      <= S_VERIFY;
              match_cnt  <= 4'd1;
              expected_q <= V_SECOND;
            end else begin
              state      <= S_HUNT;
              match_cnt  <= 4'd0;
              expected_q <= 8'h00;
            end
          end
        end
        default: begin
          state      <= S_HUNT;
          match_cnt  <= 4'd0;
          expected_q <= 8'h00;
        end
      endcase
    end
  end

  assign mon.locked    = (state == S_LOCKED);
  assign mon.err_pulse = err_pulse_q;
  assign mon.lap_count = lap_q;
  assign mon.err_count = err_q;
  assign mon.expected  = expected_q;

endmodule
